// File: rtl/mu_axiram.sv
// rtl/mu_axiram.sv - AXI4 responder backed by an internal simple-dual-port RAM
// Independent read and write channels; single legal beat size; INCR and FIXED bursts only.
module mu_axiram #(
  parameter int AXI_AW  = 32,
  parameter int AXI_DW  = 64,
  parameter int AXI_IDW = 1,
  parameter int MEM_AW  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [AXI_AW-1:0]    s_awaddr,
  input  logic [7:0]           s_awlen,
  input  logic [2:0]           s_awsize,
  input  logic [1:0]           s_awburst,
  input  logic [AXI_IDW-1:0]   s_awid,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic [AXI_DW-1:0]    s_wdata,
  input  logic [AXI_DW/8-1:0]  s_wstrb,
  input  logic                 s_wlast,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  output logic [1:0]           s_bresp,
  output logic [AXI_IDW-1:0]   s_bid,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  input  logic [AXI_AW-1:0]    s_araddr,
  input  logic [7:0]           s_arlen,
  input  logic [2:0]           s_arsize,
  input  logic [1:0]           s_arburst,
  input  logic [AXI_IDW-1:0]   s_arid,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [AXI_DW-1:0]    s_rdata,
  output logic [1:0]           s_rresp,
  output logic [AXI_IDW-1:0]   s_rid,
  output logic                 s_rlast
);

  localparam int NB  = AXI_DW / 8;
  localparam int OFF = $clog2(NB);
  localparam logic [2:0] SIZE_OK   = 3'(OFF);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                init_q;
  logic [AXI_DW-1:0]   mem_q [2**MEM_AW];

  logic [MEM_AW-1:0]   widx_q;
  logic [7:0]          wlen_q, wcnt_q;
  logic                wfix_q, werr_q, wlerr_q;
  logic [1:0]          bresp_q;
  logic [AXI_IDW-1:0]  bid_q;

  logic [MEM_AW-1:0]   ridx_q;
  logic [7:0]          rlen_q, rcnt_q;
  logic                rfix_q, rerr_q, rlast_q;
  logic [1:0]          rresp_q;
  logic [AXI_IDW-1:0]  rid_q;
  logic [AXI_DW-1:0]   rdata_q;

  logic aw_hs, w_hs, ar_hs, r_adv, w_final, aw_err, ar_err, rd_err;
  logic [MEM_AW-1:0] rd_idx;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{s_awaddr[AXI_AW-1:MEM_AW+OFF], s_awaddr[OFF-1:0],
                              s_araddr[AXI_AW-1:MEM_AW+OFF], s_araddr[OFF-1:0]};

  // Only INCR (01) and FIXED (00) are served; anything else is consumed as an error burst.
  assign aw_err  = (s_awsize != SIZE_OK) || (s_awburst[1] != 1'b0);
  assign ar_err  = (s_arsize != SIZE_OK) || (s_arburst[1] != 1'b0);
  assign aw_hs   = s_awvalid && s_awready;
  assign w_hs    = s_wvalid && s_wready;
  assign ar_hs   = s_arvalid && s_arready;
  assign r_adv   = s_rvalid && s_rready && !rlast_q;
  assign w_final = (wcnt_q == wlen_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q    <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      init_q    <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_awready = init_q;
        if (s_awvalid && init_q) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && w_final) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx_q  <= '0;
      wlen_q  <= '0;
      wcnt_q  <= '0;
      wfix_q  <= 1'b0;
      werr_q  <= 1'b0;
      wlerr_q <= 1'b0;
      bresp_q <= RESP_OKAY;
      bid_q   <= '0;
    end else begin
      if (aw_hs) begin
        widx_q  <= s_awaddr[MEM_AW+OFF-1:OFF];
        wlen_q  <= s_awlen;
        wcnt_q  <= 8'd0;
        wfix_q  <= (s_awburst == 2'b00);
        werr_q  <= aw_err;
        wlerr_q <= 1'b0;
        bid_q   <= s_awid;
      end
      if (w_hs) begin
        wcnt_q <= wcnt_q + 8'd1;
        if (!wfix_q) widx_q <= widx_q + 1'b1;
        if (s_wlast != w_final) wlerr_q <= 1'b1;
        // The burst ends on the beat count; wlast only influences the response code.
        if (w_final)
          bresp_q <= (werr_q || wlerr_q || !s_wlast) ? RESP_SLV : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !werr_q) begin
      for (int b = 0; b < NB; b++) begin
        if (s_wstrb[b]) mem_q[widx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_arready = init_q;
        if (s_arvalid && init_q) r_state_d = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready && rlast_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign rd_idx = ar_hs ? s_araddr[MEM_AW+OFF-1:OFF] : (rfix_q ? ridx_q : ridx_q + 1'b1);
  assign rd_err = ar_hs ? ar_err : rerr_q;

  // Reads are only issued on AR acceptance or an accepted non-last beat, so a stall freezes the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ridx_q  <= '0;
      rlen_q  <= '0;
      rcnt_q  <= '0;
      rfix_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rlast_q <= 1'b0;
      rresp_q <= RESP_OKAY;
      rid_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (ar_hs) begin
        rlen_q  <= s_arlen;
        rcnt_q  <= 8'd0;
        rfix_q  <= (s_arburst == 2'b00);
        rerr_q  <= ar_err;
        rid_q   <= s_arid;
        rlast_q <= (s_arlen == 8'd0);
      end
      if (r_adv) begin
        rcnt_q  <= rcnt_q + 8'd1;
        rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
      end
      if (ar_hs || r_adv) begin
        ridx_q  <= rd_idx;
        rdata_q <= rd_err ? '0 : mem_q[rd_idx];
        rresp_q <= rd_err ? RESP_SLV : RESP_OKAY;
      end
    end
  end

  assign s_bresp = bresp_q;
  assign s_bid   = bid_q;
  assign s_rdata = rdata_q;
  assign s_rresp = rresp_q;
  assign s_rid   = rid_q;
  assign s_rlast = rlast_q;

endmodule

// File: tb/tb_mu_axiram.sv
// tb/tb_mu_axiram.sv - directed self-checking bench for mu_axiram
module tb_mu_axiram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_awvalid = 1'b0, s_awready;
  logic [31:0] s_awaddr = '0;
  logic [7:0]  s_awlen = '0;
  logic [2:0]  s_awsize = 3'd3;
  logic [1:0]  s_awburst = 2'b01;
  logic [0:0]  s_awid = '0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0;
  logic        s_bvalid, s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic [0:0]  s_bid;
  logic        s_arvalid = 1'b0, s_arready;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = 3'd3;
  logic [1:0]  s_arburst = 2'b01;
  logic [0:0]  s_arid = '0;
  logic        s_rvalid, s_rready = 1'b0;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [0:0]  s_rid;
  logic        s_rlast;

  int checks = 0;
  int failures = 0;
  logic [63:0] wdat  [0:15];
  logic [63:0] exp_q [0:15];
  logic [1:0]  bresp_o;
  logic [0:0]  bid_o;
  int          nbeats, nlast, ncyc;

  always #5 clk = ~clk;

  mu_axiram dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return s_awready;
      1: return s_wready;
      2: return s_bvalid;
      default: return s_arready;
    endcase
  endfunction

  task automatic hs(input string tag, input int w);
    int n = 0;
    @(negedge clk);
    while (sig(w) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 64'(sig(w)), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input logic [7:0] strb,
                           input int bad_last);
    s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst; s_awid = id;
    s_awvalid = 1'b1;
    hs("aw", 0);
    s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1;
      s_wdata  = wdat[i];
      s_wstrb  = strb;
      s_wlast  = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      hs("w", 1);
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    s_bready = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 200 && s_bvalid !== 1'b1; n++) @(negedge clk);
    bresp_o = s_bresp;
    bid_o   = s_bid;
    check("bvalid", 64'(s_bvalid), 64'd1);
    @(posedge clk);
    #1;
    s_bready = 1'b0;
  endtask

  // mode 0: rready always high; mode 1: rready high only every third cycle (1,0,0,1,...)
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input logic [1:0] resp, input int mode);
    int k = 0;
    s_araddr = addr; s_arlen = len; s_arsize = 3'd3; s_arburst = burst; s_arid = id;
    s_arvalid = 1'b1;
    hs("ar", 3);
    s_arvalid = 1'b0;
    check("rvalid_lat", 64'(s_rvalid), 64'd1);
    nbeats = 0; nlast = 0; ncyc = 0;
    while (nbeats <= int'(len) && ncyc < 300) begin
      s_rready = (mode == 0) || (k % 3 == 0);
      @(negedge clk);
      if (s_rvalid) begin
        check("rdata", s_rdata, exp_q[nbeats]);
        check("rresp", 64'(s_rresp), 64'(resp));
        check("rid", 64'(s_rid), 64'(id));
        if (s_rready) begin
          check("rlast", 64'(s_rlast), 64'(nbeats == int'(len)));
          if (s_rlast) nlast++;
          nbeats++;
        end
      end
      @(posedge clk);
      #1;
      k++;
      ncyc++;
    end
    s_rready = 1'b0;
    check("rbeats", 64'(nbeats), 64'(int'(len) + 1));
    check("rlast_cnt", 64'(nlast), 64'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_rdata", s_rdata, 64'd0);
    check("rst_outs", 64'({s_rlast, s_bresp, s_rresp, s_bid, s_rid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_awready_pre", 64'(s_awready), 64'd0);
    @(posedge clk);
    #1;
    check("init_awready", 64'(s_awready), 64'd1);
    check("init_arready", 64'(s_arready), 64'd1);

    // INCR write of four words then read back with rready high
    wdat[0] = 64'h1111111111111111; wdat[1] = 64'h2222222222222222;
    wdat[2] = 64'h3333333333333333; wdat[3] = 64'h4444444444444444;
    axi_write(32'h100, 8'd3, 3'd3, 2'b01, 1'b1, 8'hFF, -1);
    check("incr_bresp", 64'(bresp_o), 64'd0);
    check("incr_bid", 64'(bid_o), 64'd1);
    for (int i = 0; i < 4; i++) exp_q[i] = wdat[i];
    axi_read(32'h100, 8'd3, 2'b01, 1'b1, 2'b00, 0);
    check("incr_cycles", 64'(ncyc), 64'd4);

    // partial strobe merge
    wdat[0] = 64'hAAAAAAAAAAAAAAAA;
    axi_write(32'h100, 8'd0, 3'd3, 2'b01, 1'b0, 8'h0F, -1);
    check("strb_bresp", 64'(bresp_o), 64'd0);
    exp_q[0] = 64'h11111111AAAAAAAA;
    axi_read(32'h100, 8'd0, 2'b01, 1'b0, 2'b00, 0);

    // eight-beat read with stalls
    for (int i = 0; i < 8; i++) begin
      wdat[i]  = {32'hC0DE0000 + 32'(i), 32'h00000100 + 32'(i)};
      exp_q[i] = wdat[i];
    end
    axi_write(32'h200, 8'd7, 3'd3, 2'b01, 1'b0, 8'hFF, -1);
    axi_read(32'h200, 8'd7, 2'b01, 1'b0, 2'b00, 1);

    // error bursts: bad size and WRAP, no RAM writes
    wdat[0] = 64'hFFFFFFFFFFFFFFFF; wdat[1] = 64'hFFFFFFFFFFFFFFFF;
    axi_write(32'h100, 8'd1, 3'd2, 2'b01, 1'b1, 8'hFF, -1);
    check("size_err_bresp", 64'(bresp_o), 64'd2);
    axi_write(32'h100, 8'd1, 3'd3, 2'b10, 1'b0, 8'hFF, -1);
    check("wrap_err_bresp", 64'(bresp_o), 64'd2);
    exp_q[0] = 64'h11111111AAAAAAAA; exp_q[1] = 64'h2222222222222222;
    axi_read(32'h100, 8'd1, 2'b01, 1'b0, 2'b00, 0);
    exp_q[0] = 64'd0; exp_q[1] = 64'd0;
    axi_read(32'h100, 8'd1, 2'b10, 1'b1, 2'b10, 0);

    // early wlast: all three beats consumed, SLVERR
    wdat[0] = 64'h0A; wdat[1] = 64'h0B; wdat[2] = 64'h0C;
    axi_write(32'h300, 8'd2, 3'd3, 2'b01, 1'b0, 8'hFF, 0);
    check("wlast_bresp", 64'(bresp_o), 64'd2);

    // index wrap from the last word to word 0
    wdat[0] = 64'h5555555555555555; wdat[1] = 64'h6666666666666666;
    axi_write(32'h7FF8, 8'd1, 3'd3, 2'b01, 1'b0, 8'hFF, -1);
    check("wrap_idx_bresp", 64'(bresp_o), 64'd0);
    exp_q[0] = 64'h5555555555555555;
    axi_read(32'h7FF8, 8'd0, 2'b01, 1'b0, 2'b00, 0);
    exp_q[0] = 64'h6666666666666666;
    axi_read(32'h0, 8'd0, 2'b01, 1'b0, 2'b00, 0);

    // reset in the middle of concurrent 4-beat read and write
    s_awaddr = 32'h400; s_awlen = 8'd3; s_awsize = 3'd3; s_awburst = 2'b01; s_awid = 1'b0;
    s_araddr = 32'h200; s_arlen = 8'd3; s_arsize = 3'd3; s_arburst = 2'b01; s_arid = 1'b0;
    s_awvalid = 1'b1; s_arvalid = 1'b1;
    @(negedge clk);
    check("mid_ready", 64'({s_awready, s_arready}), 64'd3);
    @(posedge clk);
    #1;
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    s_rready = 1'b1;
    s_wstrb = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      s_wvalid = 1'b1; s_wlast = 1'b0;
      s_wdata = 64'h7777000000000000 + 64'(i);
      @(posedge clk);
      #1;
    end
    s_wdata = 64'h7777000000000002;
    check("mid_rvalid", 64'(s_rvalid), 64'd1);
    check("mid_wready", 64'(s_wready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_rvalid", 64'(s_rvalid), 64'd0);
    check("arst_bvalid", 64'(s_bvalid), 64'd0);
    check("arst_wready", 64'(s_wready), 64'd0);
    check("arst_ready", 64'({s_awready, s_arready}), 64'd0);
    s_wvalid = 1'b0; s_rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready_pre", 64'({s_awready, s_arready}), 64'd0);
    @(posedge clk);
    #1;
    check("rel_ready", 64'({s_awready, s_arready}), 64'd3);

    exp_q[0] = 64'h7777000000000000; exp_q[1] = 64'h7777000000000001;
    axi_read(32'h400, 8'd1, 2'b01, 1'b0, 2'b00, 0);
    exp_q[0] = 64'h11111111AAAAAAAA;
    axi_read(32'h100, 8'd0, 2'b01, 1'b1, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      wdat[i]  = 64'h9900000000000000 + 64'(i * 3);
      exp_q[i] = wdat[i];
    end
    axi_write(32'h400, 8'd3, 3'd3, 2'b01, 1'b1, 8'hFF, -1);
    check("post_bresp", 64'(bresp_o), 64'd0);
    check("post_bid", 64'(bid_o), 64'd1);
    axi_read(32'h400, 8'd3, 2'b01, 1'b0, 2'b00, 0);

    // FIXED write repeatedly hits one word; last beat wins
    wdat[0] = 64'h0101010101010101; wdat[1] = 64'h0202020202020202;
    axi_write(32'h500, 8'd1, 3'd3, 2'b00, 1'b0, 8'hFF, -1);
    exp_q[0] = 64'h0202020202020202; exp_q[1] = 64'h0202020202020202;
    axi_read(32'h500, 8'd1, 2'b00, 1'b0, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
